serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//  Parametrised one-bit-per-clock serial frame receiver, successor to the fixed 8-bit receiver.
//  Detects the idle-high/start-low sequence, shifts DATA_W bits, checks optional parity and stop.
//  Queues good words in a FIFO drained by a valid/ready port, with error/overflow flags.
//  Sits between a sampled serial pin and the register/stream logic that consumes received words.
// PARAMETERS
//  DATA_W      8  data bits per frame (>=2)
//  MSB_FIRST   1  1: first data bit is RDATA[DATA_W-1]; 0: first data bit is RDATA[0]
//  PARITY      0  0 none, 1 even, 2 odd; parity bit follows the last data bit
//  STOP_LEVEL  0  required BITLINE value in the stop cycle
//  FIFO_DEPTH  4  received-word queue entries (power of 2, >=2)
// PORTS
//  CLK      in   1                        clock, all logic on rising edge
//  RST_N    in   1                        reset, asynchronous, active-low
//  BITLINE  in   1                        serial input, one bit per CLK, already synchronised
//  CLR_ERR  in   1                        clears FERR, PERR and OVF (synchronous pulse)
//  RVALID   out  1                        FIFO non-empty; RDATA is valid
//  RREADY   in   1                        consumer accepts RDATA when RVALID&&RREADY
//  RDATA    out  DATA_W                   FIFO head word
//  LEVEL    out  $clog2(FIFO_DEPTH+1)     words in FIFO
//  FERR     out  1                        sticky: stop cycle saw BITLINE!=STOP_LEVEL
//  PERR     out  1                        sticky: parity mismatch
//  OVF      out  1                        sticky: good frame dropped because FIFO full
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, bit count=0, shifter=0, FIFO empty; RVALID=0, LEVEL=0,
//   FERR=PERR=OVF=0, RDATA=0. Deassertion mid-frame discards the partial frame.
//  FSM, one transition per CLK:
//   IDLE   : BITLINE==1 -> ARMED; else stay.
//   ARMED  : BITLINE==0 (start bit) -> DATA, count=0, shifter=0; else stay.
//   DATA   : sample BITLINE into shifter (MSB_FIRST: shift left, insert at bit 0; else shift
//            right, insert at bit DATA_W-1); count==DATA_W-1 -> PAR if PARITY!=0 else STOP;
//            else count+1. Exactly DATA_W data cycles.
//   PAR    : latch parity bit -> STOP.
//   STOP   : evaluate frame, always -> IDLE (line must return high before next start).
//  Frame evaluation in STOP: stop_ok = (BITLINE==STOP_LEVEL); par_ok = PARITY==0 or
//   (^{data,parbit}==0 for even, ==1 for odd). Good = stop_ok && par_ok.
//   !stop_ok -> FERR<=1; !par_ok -> PERR<=1; both may set on one frame; bad frames never pushed.
//  Push: good frame written at the clock edge ending STOP; RVALID=1 from the next cycle if the
//   FIFO was empty (latency: start cycle + DATA_W [+1 parity] + 1 stop, then 1 cycle to RVALID).
//  Pop: RVALID&&RREADY at an edge removes the head; RDATA/RVALID are registered FIFO outputs,
//   RDATA holds value while RVALID&&!RREADY. RDATA when empty: last popped value (don't care).
//  Full: push with LEVEL==FIFO_DEPTH and no simultaneous pop -> word dropped, OVF<=1, FIFO intact.
//   Push and pop in same cycle when full -> both succeed, LEVEL unchanged.
//  Empty: pop ignored when RVALID=0. Pointers wrap modulo FIFO_DEPTH; LEVEL = wr-rd count.
//  CLR_ERR: clears flags at the edge; a flag-setting event in the same cycle wins (flag stays 1).
//  Flags never affect reception; RX continues after errors.
// TESTING (DATA_W=8, MSB_FIRST=1, PARITY=0, STOP_LEVEL=0, FIFO_DEPTH=4 unless noted)
//  1. BITLINE 1,0,1,0,1,0,0,1,0,1,0 with RREADY=1 -> RVALID=1 for one cycle, RDATA=8'hA5, flags 0.
//  2. Same bits with MSB_FIRST=0 -> RDATA=8'hA5 bit-reversed=8'hA5; then data 1,1,0,0,0,0,0,0 -> 8'h03.
//  3. PARITY=1, data 8'hA5 (4 ones) with parity bit 1 -> no push, PERR=1; parity bit 0 -> RDATA=8'hA5.
//  4. Stop cycle BITLINE=1 -> no push, FERR=1, LEVEL=0; CLR_ERR pulse -> FERR=0; next frame accepted.
//  5. RREADY=0, frames 8'h01..8'h05 -> LEVEL=4, OVF=1; drain yields 01,02,03,04; full+pop+push keeps LEVEL=4.
//  6. RST_N low during DATA after 3 bits -> all outputs reset values immediately; next full frame 8'h3C received.

Source files
------------

// File: rtl/serial_frame_rx.sv
// One-bit-per-clock serial frame receiver: idle-high/start-low framing, DATA_W data bits,
// optional parity, checked stop cycle, and a valid/ready FIFO of good words with sticky error flags.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY     = 0,
    parameter int STOP_LEVEL = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               BITLINE,
    input  logic                               CLR_ERR,
    output logic                               RVALID,
    input  logic                               RREADY,
    output logic [DATA_W-1:0]                  RDATA,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    LEVEL,
    output logic                               FERR,
    output logic                               PERR,
    output logic                               OVF
);

    localparam int   CNT_W    = $clog2(DATA_W);
    localparam int   PTR_W    = $clog2(FIFO_DEPTH);
    localparam int   LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic STOP_BIT = 1'(STOP_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                frame_done, stop_bad, par_bad, push_req;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ferr_q, ferr_d, perr_q, perr_d, ovf_q, ovf_d;
    logic                pop, push_ok;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (BITLINE) state_d = S_ARMED;
            S_ARMED: if (!BITLINE) state_d = S_DATA;
            S_DATA:  if (cnt_q == CNT_W'(DATA_W - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   state_d = S_STOP;
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The shifter already holds the complete word while in STOP, so it is pushed directly.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_done = 1'b0;
        stop_bad   = 1'b0;
        par_bad    = 1'b0;
        case (state_q)
            S_ARMED: begin
                if (!BITLINE) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            S_DATA: begin
                shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], BITLINE}
                                           : {BITLINE, shift_q[DATA_W-1:1]};
                cnt_d   = cnt_q + 1'b1;
            end
            S_PAR: par_d = BITLINE;
            S_STOP: begin
                frame_done = 1'b1;
                stop_bad   = (BITLINE != STOP_BIT);
                if (PARITY == 1)      par_bad = ^{shift_q, par_q};
                else if (PARITY == 2) par_bad = ~(^{shift_q, par_q});
            end
            default: ;
        endcase
        push_req = frame_done && !stop_bad && !par_bad;
    end

    // RDATA is a register tracking the head that will exist after this edge.
    always_comb begin
        pop      = (level_q != '0) && RREADY;
        push_ok  = push_req && ((level_q != LVL_W'(FIFO_DEPTH)) || pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        rdata_d  = rdata_q;
        if (pop) begin
            if (level_q > LVL_W'(1)) rdata_d = mem_q[rd_ptr_q + PTR_W'(1)];
            else if (push_ok)        rdata_d = shift_q;
        end else if ((level_q == '0) && push_ok) begin
            rdata_d = shift_q;
        end
        ferr_d = (ferr_q && !CLR_ERR) || (frame_done && stop_bad);
        perr_d = (perr_q && !CLR_ERR) || (frame_done && par_bad);
        ovf_d  = (ovf_q && !CLR_ERR) || (push_req && !push_ok);
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign RVALID = (level_q != '0);
    assign RDATA  = rdata_q;
    assign LEVEL  = level_q;
    assign FERR   = ferr_q;
    assign PERR   = perr_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: three configurations (default, LSB-first, even parity) checked
// every cycle against a frame-level queue model, plus literal expectations.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       bl [3] = '{1'b1, 1'b1, 1'b1};
    logic       ce [3] = '{1'b0, 1'b0, 1'b0};
    logic       rr [3] = '{1'b1, 1'b1, 1'b1};
    logic       rvalid [3];
    logic [7:0] rdata [3];
    logic [2:0] level [3];
    logic       ferr [3];
    logic       perr [3];
    logic       ovf [3];

    // Frame events announced by the stimulus, consumed by the model at the stop edge
    logic       ev_valid [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] ev_word [3];
    logic       ev_fe [3];
    logic       ev_pe [3];

    logic [7:0] mq [3][$];
    logic [7:0] mlast [3] = '{8'h00, 8'h00, 8'h00};
    logic       mfe [3] = '{1'b0, 1'b0, 1'b0};
    logic       mpe [3] = '{1'b0, 1'b0, 1'b0};
    logic       movf [3] = '{1'b0, 1'b0, 1'b0};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_frame_rx #(.DATA_W(8), .MSB_FIRST(1), .PARITY(0), .STOP_LEVEL(0), .FIFO_DEPTH(4)) u0 (
        .CLK(clk), .RST_N(rst_n), .BITLINE(bl[0]), .CLR_ERR(ce[0]), .RVALID(rvalid[0]),
        .RREADY(rr[0]), .RDATA(rdata[0]), .LEVEL(level[0]), .FERR(ferr[0]), .PERR(perr[0]),
        .OVF(ovf[0]));
    serial_frame_rx #(.DATA_W(8), .MSB_FIRST(0), .PARITY(0), .STOP_LEVEL(0), .FIFO_DEPTH(4)) u1 (
        .CLK(clk), .RST_N(rst_n), .BITLINE(bl[1]), .CLR_ERR(ce[1]), .RVALID(rvalid[1]),
        .RREADY(rr[1]), .RDATA(rdata[1]), .LEVEL(level[1]), .FERR(ferr[1]), .PERR(perr[1]),
        .OVF(ovf[1]));
    serial_frame_rx #(.DATA_W(8), .MSB_FIRST(1), .PARITY(1), .STOP_LEVEL(0), .FIFO_DEPTH(4)) u2 (
        .CLK(clk), .RST_N(rst_n), .BITLINE(bl[2]), .CLR_ERR(ce[2]), .RVALID(rvalid[2]),
        .RREADY(rr[2]), .RDATA(rdata[2]), .LEVEL(level[2]), .FERR(ferr[2]), .PERR(perr[2]),
        .OVF(ovf[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: pops follow RREADY, good frames join the queue unless it stays full.
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                mlast[k] = 8'h00;
                mfe[k]   = 1'b0;
                mpe[k]   = 1'b0;
                movf[k]  = 1'b0;
            end else begin
                if (mq[k].size() != 0 && rr[k]) mlast[k] = mq[k].pop_front();
                if (ce[k]) begin
                    mfe[k]  = 1'b0;
                    mpe[k]  = 1'b0;
                    movf[k] = 1'b0;
                end
                if (ev_valid[k]) begin
                    if (ev_fe[k]) mfe[k] = 1'b1;
                    if (ev_pe[k]) mpe[k] = 1'b1;
                    if (!ev_fe[k] && !ev_pe[k]) begin
                        if (mq[k].size() < 4) mq[k].push_back(ev_word[k]);
                        else movf[k] = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(mq[k].size() != 0));
            chk($sformatf("rdata%0d", k), 32'(rdata[k]),
                32'((mq[k].size() != 0) ? mq[k][0] : mlast[k]));
            chk($sformatf("level%0d", k), 32'(level[k]), 32'(mq[k].size()));
            chk($sformatf("ferr%0d", k), 32'(ferr[k]), 32'(mfe[k]));
            chk($sformatf("perr%0d", k), 32'(perr[k]), 32'(mpe[k]));
            chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(movf[k]));
        end
    end

    task automatic drive(input int k, input logic b);
        @(posedge clk);
        #1;
        bl[k] = b;
    endtask

    // Instance 1 is LSB-first, instance 2 carries an even-parity bit; all use stop level 0.
    task automatic send_frame(input int k, input logic [7:0] w, input logic pbit, input logic sbit,
                              input logic ce_stop, input logic pop_stop);
        drive(k, 1'b1);
        drive(k, 1'b0);
        for (int i = 0; i < 8; i++) drive(k, (k == 1) ? w[i] : w[7-i]);
        if (k == 2) drive(k, pbit);
        @(posedge clk);
        #1;
        bl[k]       = sbit;
        ev_word[k]  = w;
        ev_fe[k]    = (sbit != 1'b0);
        ev_pe[k]    = (k == 2) && (($countones({w, pbit}) % 2) != 0);
        ev_valid[k] = 1'b1;
        if (ce_stop) ce[k] = 1'b1;
        if (pop_stop) rr[k] = 1'b1;
        @(posedge clk);
        #1;
        ev_valid[k] = 1'b0;
        bl[k]       = 1'b1;
        if (ce_stop) ce[k] = 1'b0;
        if (pop_stop) rr[k] = 1'b0;
    endtask

    task automatic pulse_clr(input int k);
        @(posedge clk);
        #1;
        ce[k] = 1'b1;
        @(posedge clk);
        #1;
        ce[k] = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
        chk("rst_level", 32'(level[0]), 32'd0);
        chk("rst_rdata", 32'(rdata[0]), 32'h00);
        rst_n = 1'b1;

        // Basic MSB-first frame, RREADY held high
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_rvalid", 32'(rvalid[0]), 32'd1);
        chk("t1_rdata", 32'(rdata[0]), 32'hA5);
        chk("t1_ferr", 32'(ferr[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_rvalid_drop", 32'(rvalid[0]), 32'd0);

        // LSB-first
        send_frame(1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_rdata_a5", 32'(rdata[1]), 32'hA5);
        send_frame(1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_rdata_03", 32'(rdata[1]), 32'h03);

        // Even parity: bad then good
        send_frame(2, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_perr", 32'(perr[2]), 32'd1);
        chk("t3_level", 32'(level[2]), 32'd0);
        send_frame(2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_rvalid", 32'(rvalid[2]), 32'd1);
        chk("t3_rdata", 32'(rdata[2]), 32'hA5);

        // Framing error, clear, set-wins-over-clear, recovery
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_ferr", 32'(ferr[0]), 32'd1);
        chk("t4_level", 32'(level[0]), 32'd0);
        pulse_clr(0);
        chk("t4_ferr_clr", 32'(ferr[0]), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_ferr_wins", 32'(ferr[0]), 32'd1);
        pulse_clr(0);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_rdata", 32'(rdata[0]), 32'hC3);
        chk("t4_ferr_final", 32'(ferr[0]), 32'd0);

        // Overflow and drain
        @(posedge clk);
        #1;
        rr[0] = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_level", 32'(level[0]), 32'd4);
        chk("t5_ovf", 32'(ovf[0]), 32'd1);
        rr[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t5_drain%0d", i), 32'(rdata[0]), 32'(i));
            @(posedge clk);
            #1;
        end
        chk("t5_empty", 32'(rvalid[0]), 32'd0);
        rr[0] = 1'b0;
        pulse_clr(0);
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_full_level", 32'(level[0]), 32'd4);
        chk("t5_full_head", 32'(rdata[0]), 32'h12);
        chk("t5_full_ovf", 32'(ovf[0]), 32'd0);
        rr[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rr[0] = 1'b0;

        // Reset in the middle of a frame with a word queued
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid", 32'(rvalid[0]), 32'd0);
        chk("t6_level", 32'(level[0]), 32'd0);
        chk("t6_rdata", 32'(rdata[0]), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bl[0] = 1'b1;
        rr[0] = 1'b1;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rvalid_new", 32'(rvalid[0]), 32'd1);
        chk("t6_rdata_new", 32'(rdata[0]), 32'h3C);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
